// File: rtl/vit_bus_pkg.sv
// Shared types for the Viterbi decoder bank bus controller.
// Holds the bus-cycle state encoding and the fixed setup/hold phase lengths.
package vit_bus_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} vit_state_t;
  localparam int SETUP_CYC = 1;
  localparam int HOLD_CYC  = 1;
endpackage

// File: rtl/vit_bus_ctrl_if.sv
// Host request/response handshake plus device chip-select/address lines.
// master = host side, slave = controller side.
interface vit_bus_ctrl_if #(
  parameter int NUM_VIT = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int SEL_W   = $clog2(NUM_VIT)
) ();
  logic               req_valid;
  logic               req_ready;
  logic [SEL_W-1:0]   vit_num;
  logic               is_write;
  logic [ADDR_W-1:0]  in_addr;
  logic [DATA_W-1:0]  in_data;
  logic [NUM_VIT-1:0] vit_code;
  logic               vit_cs_allow;
  logic [NUM_VIT-1:0] vit_cs;
  logic [ADDR_W-1:0]  out_addr;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, vit_num, is_write, in_addr, in_data, vit_code, vit_cs_allow,
    input  req_ready, vit_cs, out_addr, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, vit_num, is_write, in_addr, in_data, vit_code, vit_cs_allow,
    output req_ready, vit_cs, out_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/vit_cs_decode.sv
// Index-to-one-hot chip-select decoder; purely combinational.
// Indices at or beyond NUM_VIT, or a low enable, give all zeros.
module vit_cs_decode #(
  parameter int NUM_VIT = 2,
  parameter int SEL_W   = $clog2(NUM_VIT)
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_VIT-1:0] cs
);
  always_comb begin
    cs = '0;
    for (int i = 0; i < NUM_VIT; i++) begin
      if (en && (sel == SEL_W'(i))) cs[i] = 1'b1;
    end
  end
endmodule

// File: rtl/vit_bus_ctrl.sv
// Sequences one host request into a setup/access/hold cycle on the shared decoder bus.
// Response ACCESS_CYC+3 cycles after accept (1 cycle on reject); one request in flight at a time.
module vit_bus_ctrl
  import vit_bus_pkg::*;
#(
  parameter int NUM_VIT    = 2,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int ACCESS_CYC = 2,
  parameter int SEL_W      = $clog2(NUM_VIT)
) (
  input  logic              clk,
  input  logic              reset,
  vit_bus_ctrl_if.slave     bus,
  inout  wire  [DATA_W-1:0] vit_data
);
  localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;

  vit_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               wr_q, wr_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  samp_q, samp_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic [NUM_VIT-1:0] cs_q, cs_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               hit;
  logic               cs_en;
  logic               drv_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    wr_d       = wr_q;
    wdat_d     = wdat_q;
    addr_d     = addr_q;
    samp_d     = samp_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    hit        = 1'b0;
    for (int i = 0; i < NUM_VIT; i++) begin
      if ((bus.vit_num == SEL_W'(i)) && bus.vit_code[i]) hit = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          sel_d  = bus.vit_num;
          wr_d   = bus.is_write;
          wdat_d = bus.in_data;
          if (hit && bus.vit_cs_allow) begin
            addr_d  = bus.in_addr;
            err_d   = 1'b0;
            state_d = SETUP;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETUP: begin
        cnt_d   = CNT_W'(ACCESS_CYC - 1);
        state_d = ACCESS;
      end
      ACCESS: begin
        // Losing permission wins over a same-cycle read sample.
        if (!bus.vit_cs_allow) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end else if (cnt_q == '0) begin
          if (!wr_q) samp_d = vit_data;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == RESP) begin
      rsp_err_d  = err_d;
      rsp_data_d = (wr_d || err_d) ? '0 : samp_d;
    end
  end

  assign ready_d     = (state_d == IDLE);
  assign rsp_valid_d = (state_d == RESP);
  assign cs_en       = (state_d == ACCESS);

  vit_cs_decode #(.NUM_VIT(NUM_VIT), .SEL_W(SEL_W)) u_cs_decode (
    .sel (sel_q),
    .en  (cs_en),
    .cs  (cs_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      wr_q        <= 1'b0;
      wdat_q      <= '0;
      addr_q      <= '0;
      samp_q      <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      cs_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      wdat_q      <= wdat_d;
      addr_q      <= addr_d;
      samp_q      <= samp_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      cs_q        <= cs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Decoded from registered state so an async reset releases the bus at once.
  assign drv_en   = wr_q && ((state_q == SETUP) || (state_q == ACCESS) || (state_q == HOLD));
  assign vit_data = drv_en ? wdat_q : {DATA_W{1'bz}};

  assign bus.req_ready = ready_q;
  assign bus.vit_cs    = cs_q;
  assign bus.out_addr  = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_vit_bus_ctrl.sv
// Randomized bench for vit_bus_ctrl: a 2-device/2-cycle instance and a 5-device/1-cycle instance,
// checked cycle by cycle against a schedule model of the bus transaction.
module tb_vit_bus_ctrl;
  logic clk;
  logic rst_a, rst_b;
  int   vecs, miss;
  logic [2:0] model_addr_a;

  wire  [7:0] vd_a, vd_b;
  logic       dev_en_a, dev_en_b;
  logic [7:0] dev_dat_a, dev_dat_b;
  assign vd_a = dev_en_a ? dev_dat_a : 8'hzz;
  assign vd_b = dev_en_b ? dev_dat_b : 8'hzz;

  vit_bus_ctrl_if #(.NUM_VIT(2), .DATA_W(8), .ADDR_W(3)) ifa ();
  vit_bus_ctrl_if #(.NUM_VIT(5), .DATA_W(8), .ADDR_W(3)) ifb ();

  vit_bus_ctrl #(.NUM_VIT(2), .DATA_W(8), .ADDR_W(3), .ACCESS_CYC(2)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.slave), .vit_data(vd_a));
  vit_bus_ctrl #(.NUM_VIT(5), .DATA_W(8), .ADDR_W(3), .ACCESS_CYC(1)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.slave), .vit_data(vd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic test_reset;
    @(negedge clk);
    vecs++; if (ifa.req_ready !== 1'b0 || ifa.vit_cs !== 2'b00 || ifa.out_addr !== 3'd0) begin
      miss++; $display("FAIL rst_a_ctl got rdy=%b cs=%b addr=%h want 0 0 0", ifa.req_ready, ifa.vit_cs, ifa.out_addr); end
    vecs++; if (ifa.rsp_valid !== 1'b0 || ifa.rsp_data !== 8'h00 || ifa.rsp_err !== 1'b0) begin
      miss++; $display("FAIL rst_a_rsp got v=%b d=%h e=%b want 0 00 0", ifa.rsp_valid, ifa.rsp_data, ifa.rsp_err); end
    vecs++; if (ifb.req_ready !== 1'b0 || ifb.vit_cs !== 5'b0 || ifb.rsp_valid !== 1'b0) begin
      miss++; $display("FAIL rst_b_ctl got rdy=%b cs=%b v=%b want 0 0 0", ifb.req_ready, ifb.vit_cs, ifb.rsp_valid); end
    dev_en_a = 1'b1; dev_dat_a = 8'h00; dev_en_b = 1'b1; dev_dat_b = 8'h00; #1;
    vecs++; if (vd_a !== 8'h00 || vd_b !== 8'h00) begin
      miss++; $display("FAIL rst_bus_released got a=%h b=%h want 00 00", vd_a, vd_b); end
    dev_en_a = 1'b0; dev_en_b = 1'b0;
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; #1;
    vecs++; if (ifa.req_ready !== 1'b0) begin
      miss++; $display("FAIL rdy_before_edge got %b want 0", ifa.req_ready); end
    @(negedge clk);
    vecs++; if (ifa.req_ready !== 1'b1 || ifb.req_ready !== 1'b1) begin
      miss++; $display("FAIL rdy_after_edge got a=%b b=%b want 1 1", ifa.req_ready, ifb.req_ready); end
  endtask

  // One request on the 2-device instance; abort_at = ACCESS cycle (1..2) in which permission drops, 0 = none.
  task automatic run_a(input logic num, input logic wr, input logic [2:0] addr, input logic [7:0] wdat,
                       input logic [1:0] code, input logic allow, input int abort_at, input logic [7:0] dev,
                       input logic scramble_code);
    logic acc, ab, exp_v, exp_r, exp_e;
    logic [1:0] oh, exp_cs;
    logic [7:0] exp_d;
    int endp, rsp_k, w;
    acc   = code[num] && allow;
    ab    = acc && (abort_at >= 1) && (abort_at <= 2);
    endp  = ab ? 1 + abort_at : 3;
    rsp_k = acc ? endp + 2 : 1;
    oh    = 2'b01 << num;
    exp_e = !acc || ab;
    exp_d = (wr || exp_e) ? 8'h00 : dev;
    w = 0;
    while (ifa.req_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    vecs++; if (ifa.req_ready !== 1'b1) begin
      miss++; $display("FAIL ready_wait got %b want 1", ifa.req_ready); end
    ifa.vit_num = num; ifa.is_write = wr; ifa.in_addr = addr; ifa.in_data = wdat;
    ifa.vit_code = code; ifa.vit_cs_allow = allow; ifa.req_valid = 1'b1;
    dev_en_a = !wr; dev_dat_a = dev;
    @(posedge clk);
    if (acc) model_addr_a = addr;
    for (int k = 1; k <= rsp_k + 1; k++) begin
      @(negedge clk);
      if (k == 1) ifa.req_valid = 1'b0;
      if (k == 2 && scramble_code) ifa.vit_code = ~code;
      if (ab && k == endp) ifa.vit_cs_allow = 1'b0;
      if (k == endp + 1) ifa.vit_cs_allow = 1'b1;
      exp_cs = (acc && k >= 2 && k <= endp) ? oh : 2'b00;
      exp_v  = (k == rsp_k);
      exp_r  = (k > rsp_k);
      vecs++; if (ifa.vit_cs !== exp_cs) begin
        miss++; $display("FAIL cs k=%0d got %b want %b", k, ifa.vit_cs, exp_cs); end
      vecs++; if (ifa.rsp_valid !== exp_v || ifa.req_ready !== exp_r) begin
        miss++; $display("FAIL hs k=%0d got v=%b r=%b want v=%b r=%b", k, ifa.rsp_valid, ifa.req_ready, exp_v, exp_r); end
      vecs++; if (ifa.out_addr !== model_addr_a) begin
        miss++; $display("FAIL out_addr k=%0d got %h want %h", k, ifa.out_addr, model_addr_a); end
      if (k >= rsp_k) begin
        vecs++; if (ifa.rsp_data !== exp_d || ifa.rsp_err !== exp_e) begin
          miss++; $display("FAIL rsp k=%0d got d=%h e=%b want d=%h e=%b", k, ifa.rsp_data, ifa.rsp_err, exp_d, exp_e); end
      end
      if (!wr) begin
        vecs++; if (vd_a !== dev) begin
          miss++; $display("FAIL rd_bus k=%0d got %h want %h", k, vd_a, dev); end
      end else if (acc && k <= endp + 1) begin
        vecs++; if (vd_a !== wdat) begin
          miss++; $display("FAIL wr_bus k=%0d got %h want %h", k, vd_a, wdat); end
      end else begin
        dev_en_a = 1'b1; dev_dat_a = 8'h00; #1;
        vecs++; if (vd_a !== 8'h00) begin
          miss++; $display("FAIL bus_release k=%0d got %h want 00", k, vd_a); end
        dev_en_a = 1'b0;
      end
    end
    dev_en_a = 1'b0;
  endtask

  task automatic test_read;
    run_a(1'b1, 1'b0, 3'b010, 8'h00, 2'b11, 1'b1, 0, 8'hAB, 1'b0);
  endtask

  task automatic test_write;
    run_a(1'b0, 1'b1, 3'b101, 8'b10101011, 2'b11, 1'b1, 0, 8'h00, 1'b0);
  endtask

  task automatic test_reject;
    run_a(1'b0, 1'b0, 3'b111, 8'h00, 2'b10, 1'b1, 0, 8'h5C, 1'b0);
    run_a(1'b1, 1'b1, 3'b011, 8'h77, 2'b11, 1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic test_abort;
    run_a(1'b1, 1'b0, 3'b001, 8'h00, 2'b11, 1'b1, 1, 8'hE7, 1'b0);
    run_a(1'b0, 1'b1, 3'b110, 8'h3D, 2'b01, 1'b1, 2, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      run_a(i[0], i[1], 3'(i), 8'(8'h10 + i), 2'b11, 1'b1, 0, 8'(8'hC0 + i), 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      run_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
            2'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0,
            8'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_five_dev;
    logic [4:0] exp_cs;
    @(negedge clk);
    ifb.vit_num = 3'd6; ifb.is_write = 1'b0; ifb.in_addr = 3'd1; ifb.in_data = 8'h00;
    ifb.vit_code = 5'b11111; ifb.vit_cs_allow = 1'b1; ifb.req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    ifb.req_valid = 1'b0;
    vecs++; if (ifb.rsp_valid !== 1'b1 || ifb.rsp_err !== 1'b1 || ifb.vit_cs !== 5'b0) begin
      miss++; $display("FAIL b_oor got v=%b e=%b cs=%b want 1 1 00000", ifb.rsp_valid, ifb.rsp_err, ifb.vit_cs); end
    @(negedge clk);
    vecs++; if (ifb.req_ready !== 1'b1) begin
      miss++; $display("FAIL b_rdy got %b want 1", ifb.req_ready); end
    ifb.vit_num = 3'd4; ifb.in_addr = 3'd5; ifb.req_valid = 1'b1;
    dev_en_b = 1'b1; dev_dat_b = 8'h3C;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) ifb.req_valid = 1'b0;
      exp_cs = (k == 2) ? 5'b10000 : 5'b00000;
      vecs++; if (ifb.vit_cs !== exp_cs || ifb.rsp_valid !== (k == 4)) begin
        miss++; $display("FAIL b_rd k=%0d got cs=%b v=%b want cs=%b v=%b", k, ifb.vit_cs, ifb.rsp_valid, exp_cs, (k == 4)); end
    end
    vecs++; if (ifb.rsp_data !== 8'h3C || ifb.rsp_err !== 1'b0 || ifb.out_addr !== 3'd5) begin
      miss++; $display("FAIL b_rd_rsp got d=%h e=%b a=%h want 3c 0 5", ifb.rsp_data, ifb.rsp_err, ifb.out_addr); end
    dev_en_b = 1'b0;
    @(negedge clk);
    ifb.is_write = 1'b1; ifb.in_data = 8'h5A; ifb.req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    ifb.req_valid = 1'b0;
    @(negedge clk);
    vecs++; if (ifb.vit_cs !== 5'b10000 || vd_b !== 8'h5A) begin
      miss++; $display("FAIL b_access got cs=%b bus=%h want 10000 5a", ifb.vit_cs, vd_b); end
    #1 rst_b = 1'b1;
    #1;
    vecs++; if (ifb.vit_cs !== 5'b0) begin
      miss++; $display("FAIL b_rst_cs got %b want 00000", ifb.vit_cs); end
    dev_en_b = 1'b1; dev_dat_b = 8'h00; #1;
    vecs++; if (vd_b !== 8'h00) begin
      miss++; $display("FAIL b_rst_bus got %h want 00", vd_b); end
    dev_en_b = 1'b0;
    vecs++; if (ifb.rsp_data !== 8'h00 || ifb.out_addr !== 3'd0) begin
      miss++; $display("FAIL b_rst_regs got d=%h a=%h want 00 0", ifb.rsp_data, ifb.out_addr); end
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vecs++; if (ifb.rsp_valid !== 1'b0 || ifb.vit_cs !== 5'b0) begin
        miss++; $display("FAIL b_no_rsp k=%0d got v=%b cs=%b want 0 00000", k, ifb.rsp_valid, ifb.vit_cs); end
    end
  endtask

  initial begin
    vecs = 0; miss = 0; model_addr_a = 3'd0;
    rst_a = 1'b1; rst_b = 1'b1;
    dev_en_a = 1'b0; dev_en_b = 1'b0; dev_dat_a = 8'h00; dev_dat_b = 8'h00;
    ifa.req_valid = 1'b0; ifa.vit_num = '0; ifa.is_write = 1'b0; ifa.in_addr = '0;
    ifa.in_data = '0; ifa.vit_code = '0; ifa.vit_cs_allow = 1'b0;
    ifb.req_valid = 1'b0; ifb.vit_num = '0; ifb.is_write = 1'b0; ifb.in_addr = '0;
    ifb.in_data = '0; ifb.vit_code = '0; ifb.vit_cs_allow = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_reject();
    test_abort();
    test_back_to_back();
    test_random();
    test_five_dev();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/vit_bus_ctrl.md
# vit_bus_ctrl

Parametrised chip-select and bus controller for a bank of NUM_VIT Viterbi decoder devices sharing one address bus and one bidirectional data bus. It accepts single read/write requests over a valid/ready handshake. Each request is qualified against per-device presence codes and a global chip-select enable, then sequenced through a setup/access/hold bus cycle. The controller returns one response (data plus error flag) per request. It sits between the host register logic and the external decoder devices, generalising the fixed two-device combinational selector to N devices with timed, registered bus cycles.

## Interface
- NUM_VIT, default 2: number of decoder devices (≥2).
- DATA_W, default 8: data bus width.
- ADDR_W, default 3: device register address width.
- ACCESS_CYC, default 2: cycles chip select is held active (≥1).
- SEL_W, default $clog2(NUM_VIT): device-select width (derived).
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- vit_num  in  SEL_W  target device index.
- is_write  in  1  1 = write, 0 = read.
- in_addr  in  ADDR_W  device register address.
- in_data  in  DATA_W  write data.
- vit_code  in  NUM_VIT  per-device present/enabled code.
- vit_cs_allow  in  1  global chip-select permission.
- vit_cs  out  NUM_VIT  one-hot active-high chip selects.
- out_addr  out  ADDR_W  registered address to devices.
- vit_data  inout  DATA_W  shared device data bus.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  request rejected or aborted.

## Operation
- States: IDLE, SETUP, ACCESS, HOLD, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch vit_num, is_write, in_addr, in_data.
  - Reject and go to RESP with err=1 if vit_num≥NUM_VIT, vit_code[vit_num]=0, or vit_cs_allow=0. No chip select asserts on a rejected request.
  - Otherwise go to SETUP.
- SETUP (1 cycle): out_addr driven with the latched address; vit_cs all 0; write data driven if is_write.
- ACCESS (ACCESS_CYC cycles, down-counter): vit_cs[sel]=1, all other bits 0.
  - Read: sample vit_data into rsp_data on the last ACCESS cycle.
- HOLD (1 cycle): vit_cs=0; address and write data held.
- RESP (1 cycle): rsp_valid=1; next state IDLE.
- vit_data is driven with the latched data only while is_write and the state is SETUP/ACCESS/HOLD. It is 'z at all other times, including during reset.
- Abort: vit_cs_allow=0 sampled during ACCESS → vit_cs drops at the next edge, the state goes to HOLD, err=1, and rsp_data=0.
- vit_code changes after acceptance are ignored.
- out_addr keeps its last value after a transaction. rsp_data and rsp_err hold until the next RESP.
- Reset values: state IDLE, req_ready=0, vit_cs=0, out_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, vit_data='z. req_ready rises on the first edge after reset deasserts.
- Reset mid-transaction: chip select and the bus are released immediately (asynchronously). No response is issued for the killed request.

## Timing
- All outputs are registered except the vit_data tri-state enable, which is decoded from registered state.
- Accepted at edge T0: SETUP in cycle T0+1; ACCESS in T0+2..T0+1+ACCESS_CYC; HOLD in T0+2+ACCESS_CYC; rsp_valid in T0+3+ACCESS_CYC.
- Rejected at T0: rsp_valid in T0+1 with err=1.
- req_ready is low from T0+1 until the RESP cycle ends, so back-to-back throughput is one request per ACCESS_CYC+4 cycles.
- Read sample edge is the edge that ends the last ACCESS cycle. Device data must be valid by then.
- Chip select never overlaps between devices. There is at least one cs-low cycle between consecutive transactions.

## Structure
- Package vit_bus_pkg contains:
  - typedef enum vit_state_t {IDLE, SETUP, ACCESS, HOLD, RESP};
  - localparam SETUP_CYC=1 and HOLD_CYC=1.
- Sub-module vit_cs_decode: SEL_W index plus enable in, NUM_VIT one-hot out. Out-of-range index yields all 0.
- Top level contains the FSM, access counter, latches, and tri-state driver.

## Test plan
- Reset with NUM_VIT=2, ACCESS_CYC=2 → every output is at its reset value and vit_data is 'z. req_ready=1 one edge after release.
- Read: vit_num=1, vit_code=2'b11, allow=1, in_addr=3'b010, device drives 8'hAB → vit_cs=2'b10 for exactly 2 cycles, out_addr=3'b010, rsp_valid 5 cycles after accept, rsp_data=8'hAB, err=0.
- Write: vit_num=0, in_data=8'b10101011 → vit_data=8'hAB from SETUP through HOLD, vit_cs=2'b01 during ACCESS, then bus 'z. Response has rsp_data=0, err=0.
- Rejection: vit_code=2'b10 with vit_num=0, and separately allow=0 → vit_cs stays 0, rsp_valid next cycle with err=1.
- Abort: allow drops in the first ACCESS cycle → vit_cs low at the next edge, HOLD, response with err=1, rsp_data=0.
- NUM_VIT=5, ACCESS_CYC=1: vit_num=6 → rejected. vit_num=4 → vit_cs=5'b10000 for 1 cycle. Asserting reset mid-ACCESS releases cs and the bus immediately, and no rsp_valid follows.
